// File: rtl/reg_file_wb.sv
// Register file with write-back scoreboard.
// Registered read ports, same-cycle write bypass, per-register busy bits.
module reg_file_wb #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          Clk6,
    input  logic          Reset_n,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] ans_wb,
    input  logic          rd_en,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_addr,
    output logic          stall,
    output logic [AW:0]   pend_cnt
);

    localparam int NR = 1 << AW;

    logic [DW-1:0] regs [NR];
    logic [NR-1:0] busy;
    logic [NR-1:0] eb;
    logic [NR-1:0] busy_nxt;
    logic [AW:0]   cnt_nxt;
    logic          wb_hit;
    logic          issue_ok;
    logic          rd_ok;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

    assign wb_hit   = wb_en && (wb_addr != '0);
    assign stall    = rd_en && (eb[rs_addr] || eb[rt_addr]);
    assign issue_ok = issue_en && !stall && (issue_addr != '0);
    assign rd_ok    = rd_en && !stall;

    // Busy bits as seen by this cycle's reads: the register being written back is ready.
    always_comb begin
        eb = busy;
        if (wb_hit) begin
            eb[wb_addr] = 1'b0;
        end
        eb[0] = 1'b0;
    end

    // Next busy state: write-back clears, accepted issue sets (issue wins a tie).
    always_comb begin
        busy_nxt = busy;
        if (wb_hit) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_nxt[issue_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Popcount of the next busy vector.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NR; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    // Operand selection with write-back bypass; R0 is constant zero.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs_addr != '0) begin
            rs_val = (wb_hit && wb_addr == rs_addr) ? ans_wb : regs[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_val = (wb_hit && wb_addr == rt_addr) ? ans_wb : regs[rt_addr];
        end
    end

    // Register storage write port.
    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NR; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[wb_addr] <= ans_wb;
        end
    end

    // Scoreboard state and pending count.
    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Registered read ports; hold while idle or stalled.
    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            rs_data <= '0;
            rt_data <= '0;
        end else if (rd_ok) begin
            rs_data <= rs_val;
            rt_data <= rt_val;
        end
    end

endmodule
